ex_ctrl_stage: RTL and testbench



---
 rtl/ex_ctrl_stage_pkg.sv | 58 +++++
 rtl/ex_ctrl_stage_if.sv | 61 ++++++
 rtl/ex_ctrl_stage_ex.sv | 196 +++++++++++++++++++
 rtl/ex_ctrl_stage.sv | 115 +++++++++++
 tb/tb_ex_ctrl_stage.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_ctrl_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_ctrl_stage_pkg
// Shared definitions for the XPU RV64I execute-stage cluster: bus widths,
// RV64I opcode / funct3 constants, the stage-control encodings and the
// internal ALU operation selector.
// ---------------------------------------------------------------------------
package ex_ctrl_stage_pkg;

    localparam int XLEN    = 64;
    localparam int ILEN    = 32;
    localparam int RADDR_W = 5;

    // Major opcodes handled in EX
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

    // funct3 for OP / OP-IMM / OP-32 / OP-IMM-32
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Pipeline-register control: RUN captures, STALL holds, FLUSH loads a bubble
    typedef enum logic [1:0] {
        CTRL_RUN   = 2'b00,
        CTRL_STALL = 2'b01,
        CTRL_FLUSH = 2'b10
    } ctrl_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_NONE
    } alu_op_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ex_ctrl_stage_if.sv
// ---------------------------------------------------------------------------
// ex_ctrl_stage_if
// Bundle of every non-clock signal of the execute-stage cluster.
//   *_i : ID/EX operands, MEM forwarding path and icache valid (into EX)
//   *_o : EX/MEM register, EX forwarding path, stage controls, PC redirect
// modport slave  : used by ex_ctrl_stage
// modport master : used by the surrounding pipeline (drives *_i)
// ---------------------------------------------------------------------------
interface ex_ctrl_stage_if;
    import ex_ctrl_stage_pkg::*;

    logic                 icache_data_valid_i;
    logic [RADDR_W-1:0]   rs1_addr_i;
    logic [RADDR_W-1:0]   rs2_addr_i;
    logic [6:0]           opcode_i;
    logic [2:0]           funct3_i;
    logic [6:0]           funct7_i;
    logic [XLEN-1:0]      rs1_data_i;
    logic [XLEN-1:0]      rs2_data_i;
    logic [RADDR_W-1:0]   rd_addr_i;
    logic                 wreg_i;
    logic [ILEN-1:0]      imm_i;
    logic [11:0]          offset12_i;
    logic [XLEN-1:0]      pc_i;
    logic [RADDR_W-1:0]   mem_back_rd_addr_i;
    logic                 mem_back_wreg_i;
    logic [XLEN-1:0]      mem_back_wdata_i;

    logic [RADDR_W-1:0]   rd_addr_o;
    logic                 wreg_o;
    logic [XLEN-1:0]      wdata_o;
    logic [RADDR_W-1:0]   ex_back_rd_addr_o;
    logic                 ex_back_wreg_o;
    logic [XLEN-1:0]      ex_back_wdata_o;
    logic [1:0]           ctrl_signal_pc_o;
    logic [1:0]           ctrl_signal_if_id_o;
    logic [1:0]           ctrl_signal_id_ex_o;
    logic [1:0]           ctrl_signal_mem_wb_o;
    logic [XLEN-1:0]      ctrl_to_pc_new_o;

    modport slave (
        input  icache_data_valid_i, rs1_addr_i, rs2_addr_i, opcode_i, funct3_i,
               funct7_i, rs1_data_i, rs2_data_i, rd_addr_i, wreg_i, imm_i,
               offset12_i, pc_i, mem_back_rd_addr_i, mem_back_wreg_i,
               mem_back_wdata_i,
        output rd_addr_o, wreg_o, wdata_o, ex_back_rd_addr_o, ex_back_wreg_o,
               ex_back_wdata_o, ctrl_signal_pc_o, ctrl_signal_if_id_o,
               ctrl_signal_id_ex_o, ctrl_signal_mem_wb_o, ctrl_to_pc_new_o
    );

    modport master (
        output icache_data_valid_i, rs1_addr_i, rs2_addr_i, opcode_i, funct3_i,
               funct7_i, rs1_data_i, rs2_data_i, rd_addr_i, wreg_i, imm_i,
               offset12_i, pc_i, mem_back_rd_addr_i, mem_back_wreg_i,
               mem_back_wdata_i,
        input  rd_addr_o, wreg_o, wdata_o, ex_back_rd_addr_o, ex_back_wreg_o,
               ex_back_wdata_o, ctrl_signal_pc_o, ctrl_signal_if_id_o,
               ctrl_signal_id_ex_o, ctrl_signal_mem_wb_o, ctrl_to_pc_new_o
    );

endinterface

// File: rtl/ex_ctrl_stage_ex.sv
// ---------------------------------------------------------------------------
// ex_ctrl_stage_ex
// Combinational EX unit: MEM->EX operand forwarding, instruction decode,
// 64/32-bit ALU, branch comparison and jump/branch target generation.
// Inputs : i_* ID/EX fields and the MEM forwarding path
// Outputs: o_wdata (writeback value), o_wreg (effective write enable),
//          o_taken (redirect required), o_target (redirect address)
// ---------------------------------------------------------------------------
module ex_ctrl_stage_ex
    import ex_ctrl_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] i_rs1_addr,
    input  logic [RADDR_W-1:0] i_rs2_addr,
    input  logic [6:0]         i_opcode,
    input  logic [2:0]         i_funct3,
    input  logic [6:0]         i_funct7,
    input  logic [XLEN-1:0]    i_rs1_data,
    input  logic [XLEN-1:0]    i_rs2_data,
    input  logic [RADDR_W-1:0] i_rd_addr,
    input  logic               i_wreg,
    input  logic [ILEN-1:0]    i_imm,
    input  logic [11:0]        i_offset12,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [RADDR_W-1:0] i_mem_rd_addr,
    input  logic               i_mem_wreg,
    input  logic [XLEN-1:0]    i_mem_wdata,
    output logic [XLEN-1:0]    o_wdata,
    output logic               o_wreg,
    output logic               o_taken,
    output logic [XLEN-1:0]    o_target
);

    logic [RADDR_W-1:0] w_src_addr [2];
    logic [XLEN-1:0]    w_src_data [2];
    logic [XLEN-1:0]    w_opnd     [2];

    assign w_src_addr[0] = i_rs1_addr;
    assign w_src_addr[1] = i_rs2_addr;
    assign w_src_data[0] = i_rs1_data;
    assign w_src_data[1] = i_rs2_data;

    // A write to x0 in MEM is never a real producer, so it must not forward.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_opnd[gi] = (i_mem_wreg && (i_mem_rd_addr != '0) &&
                                 (i_mem_rd_addr == w_src_addr[gi]))
                                ? i_mem_wdata : w_src_data[gi];
        end
    endgenerate

    logic [XLEN-1:0] w_imm64;
    logic [XLEN-1:0] w_boff64;
    assign w_imm64  = sext32(i_imm);
    assign w_boff64 = {{51{i_offset12[11]}}, i_offset12, 1'b0};

    // Only funct7[5] distinguishes SUB/SRA; remaining bits are don't-care.
    logic w_unused;
    assign w_unused = ^{i_funct7[6], i_funct7[4:0]};

    alu_op_e         w_alu_op;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;
    logic            w_word;
    logic            w_writes;
    logic            w_link;
    logic            w_jump;
    logic            w_branch;
    logic [XLEN-1:0] w_target;

    always_comb begin
        w_alu_op = ALU_NONE;
        w_alu_a  = w_opnd[0];
        w_alu_b  = w_opnd[1];
        w_word   = 1'b0;
        w_writes = 1'b0;
        w_link   = 1'b0;
        w_jump   = 1'b0;
        w_branch = 1'b0;
        w_target = '0;
        case (i_opcode)
            OPC_OP_IMM, OPC_OP: begin
                w_writes = 1'b1;
                if (i_opcode == OPC_OP_IMM) w_alu_b = w_imm64;
                case (i_funct3)
                    F3_ADD:  w_alu_op = (i_opcode == OPC_OP && i_funct7[5]) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  w_alu_op = ALU_SLL;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_SR:   w_alu_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:   w_alu_op = ALU_OR;
                    F3_AND:  w_alu_op = ALU_AND;
                    default: w_alu_op = ALU_NONE;
                endcase
            end
            OPC_OP_IMM_32, OPC_OP_32: begin
                w_writes = 1'b1;
                w_word   = 1'b1;
                if (i_opcode == OPC_OP_IMM_32) w_alu_b = w_imm64;
                case (i_funct3)
                    F3_ADD:  w_alu_op = (i_opcode == OPC_OP_32 && i_funct7[5]) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  w_alu_op = ALU_SLL;
                    F3_SR:   w_alu_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    default: w_alu_op = ALU_NONE;
                endcase
            end
            OPC_LUI: begin
                w_writes = 1'b1;
                w_alu_op = ALU_PASS_B;
                w_alu_b  = w_imm64;
            end
            OPC_AUIPC: begin
                w_writes = 1'b1;
                w_alu_op = ALU_ADD;
                w_alu_a  = i_pc;
                w_alu_b  = w_imm64;
            end
            OPC_JAL: begin
                w_writes = 1'b1;
                w_link   = 1'b1;
                w_jump   = 1'b1;
                w_target = i_pc + w_imm64;
            end
            OPC_JALR: begin
                w_writes = 1'b1;
                w_link   = 1'b1;
                w_jump   = 1'b1;
                w_target = (w_opnd[0] + w_imm64) & ~64'd1;
            end
            OPC_BRANCH: begin
                w_branch = 1'b1;
                w_target = i_pc + w_boff64;
            end
            default: ;
        endcase
    end

    // 64-bit and 32-bit ALU lanes; the word lane is sign-extended afterwards.
    logic [XLEN-1:0] w_res64;
    logic [31:0]     w_res32;
    logic [31:0]     w_a32;
    logic [31:0]     w_b32;
    assign w_a32 = w_alu_a[31:0];
    assign w_b32 = w_alu_b[31:0];

    always_comb begin
        w_res64 = '0;
        case (w_alu_op)
            ALU_ADD:    w_res64 = w_alu_a + w_alu_b;
            ALU_SUB:    w_res64 = w_alu_a - w_alu_b;
            ALU_SLL:    w_res64 = w_alu_a << w_alu_b[5:0];
            ALU_SLT:    w_res64 = {63'b0, $signed(w_alu_a) < $signed(w_alu_b)};
            ALU_SLTU:   w_res64 = {63'b0, w_alu_a < w_alu_b};
            ALU_XOR:    w_res64 = w_alu_a ^ w_alu_b;
            ALU_SRL:    w_res64 = w_alu_a >> w_alu_b[5:0];
            ALU_SRA:    w_res64 = $signed(w_alu_a) >>> w_alu_b[5:0];
            ALU_OR:     w_res64 = w_alu_a | w_alu_b;
            ALU_AND:    w_res64 = w_alu_a & w_alu_b;
            ALU_PASS_B: w_res64 = w_alu_b;
            default:    w_res64 = '0;
        endcase
    end

    always_comb begin
        w_res32 = '0;
        case (w_alu_op)
            ALU_ADD: w_res32 = w_a32 + w_b32;
            ALU_SUB: w_res32 = w_a32 - w_b32;
            ALU_SLL: w_res32 = w_a32 << w_b32[4:0];
            ALU_SRL: w_res32 = w_a32 >> w_b32[4:0];
            ALU_SRA: w_res32 = $signed(w_a32) >>> w_b32[4:0];
            default: w_res32 = '0;
        endcase
    end

    logic w_cond;
    always_comb begin
        w_cond = 1'b0;
        case (i_funct3)
            F3_BEQ:  w_cond = (w_opnd[0] == w_opnd[1]);
            F3_BNE:  w_cond = (w_opnd[0] != w_opnd[1]);
            F3_BLT:  w_cond = ($signed(w_opnd[0]) <  $signed(w_opnd[1]));
            F3_BGE:  w_cond = ($signed(w_opnd[0]) >= $signed(w_opnd[1]));
            F3_BLTU: w_cond = (w_opnd[0] <  w_opnd[1]);
            F3_BGEU: w_cond = (w_opnd[0] >= w_opnd[1]);
            default: w_cond = 1'b0;
        endcase
    end

    assign o_wdata  = w_link ? (i_pc + 64'd4) : (w_word ? sext32(w_res32) : w_res64);
    assign o_wreg   = i_wreg && (i_rd_addr != '0) && w_writes;
    assign o_taken  = w_jump || (w_branch && w_cond);
    assign o_target = w_target;

endmodule

// File: rtl/ex_ctrl_stage.sv
// ---------------------------------------------------------------------------
// ex_ctrl_stage
// Execute-stage cluster: EX unit, EX/MEM pipeline register and the hazard
// controller that drives stall/flush for every pipeline register.
// Ports:
//   clk  : pipeline clock
//   rst  : asynchronous active-low reset (clears EX/MEM)
//   bus  : ex_ctrl_stage_if.slave -- ID/EX operands, MEM forwarding path,
//          icache valid in; EX/MEM outputs, EX forwarding, controls out
// ---------------------------------------------------------------------------
module ex_ctrl_stage
    import ex_ctrl_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    ex_ctrl_stage_if.slave      bus
);

    logic [XLEN-1:0] w_ex_wdata;
    logic            w_ex_wreg;
    logic            w_ex_taken;
    logic [XLEN-1:0] w_ex_target;

    ex_ctrl_stage_ex u_ex (
        .i_rs1_addr    (bus.rs1_addr_i),
        .i_rs2_addr    (bus.rs2_addr_i),
        .i_opcode      (bus.opcode_i),
        .i_funct3      (bus.funct3_i),
        .i_funct7      (bus.funct7_i),
        .i_rs1_data    (bus.rs1_data_i),
        .i_rs2_data    (bus.rs2_data_i),
        .i_rd_addr     (bus.rd_addr_i),
        .i_wreg        (bus.wreg_i),
        .i_imm         (bus.imm_i),
        .i_offset12    (bus.offset12_i),
        .i_pc          (bus.pc_i),
        .i_mem_rd_addr (bus.mem_back_rd_addr_i),
        .i_mem_wreg    (bus.mem_back_wreg_i),
        .i_mem_wdata   (bus.mem_back_wdata_i),
        .o_wdata       (w_ex_wdata),
        .o_wreg        (w_ex_wreg),
        .o_taken       (w_ex_taken),
        .o_target      (w_ex_target)
    );

    assign bus.ex_back_rd_addr_o = bus.rd_addr_i;
    assign bus.ex_back_wreg_o    = w_ex_wreg;
    assign bus.ex_back_wdata_o   = w_ex_wdata;

    // Hazard control. A redirect outranks an icache miss: the fetched
    // instruction is on the wrong path anyway, so it is flushed either way.
    // EX/MEM always runs so the branch/jump retires its link write.
    ctrl_e           w_ctrl_pc;
    ctrl_e           w_ctrl_if_id;
    ctrl_e           w_ctrl_id_ex;
    ctrl_e           w_ctrl_mem_wb;
    ctrl_e           w_ctrl_ex_mem;
    logic [XLEN-1:0] w_pc_new;

    always_comb begin
        w_ctrl_pc     = CTRL_RUN;
        w_ctrl_if_id  = CTRL_RUN;
        w_ctrl_id_ex  = CTRL_RUN;
        w_ctrl_mem_wb = CTRL_RUN;
        w_ctrl_ex_mem = CTRL_RUN;
        w_pc_new      = '0;
        if (w_ex_taken) begin
            w_ctrl_pc    = CTRL_FLUSH;
            w_ctrl_if_id = CTRL_FLUSH;
            w_ctrl_id_ex = CTRL_FLUSH;
            w_pc_new     = w_ex_target;
        end else if (!bus.icache_data_valid_i) begin
            w_ctrl_pc    = CTRL_STALL;
            w_ctrl_if_id = CTRL_FLUSH;
        end
    end

    assign bus.ctrl_signal_pc_o     = w_ctrl_pc;
    assign bus.ctrl_signal_if_id_o  = w_ctrl_if_id;
    assign bus.ctrl_signal_id_ex_o  = w_ctrl_id_ex;
    assign bus.ctrl_signal_mem_wb_o = w_ctrl_mem_wb;
    assign bus.ctrl_to_pc_new_o     = w_pc_new;

    // EX/MEM pipeline register
    logic [RADDR_W-1:0] r_rd_addr;
    logic               r_wreg;
    logic [XLEN-1:0]    r_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_addr <= '0;
            r_wreg    <= 1'b0;
            r_wdata   <= '0;
        end else begin
            case (w_ctrl_ex_mem)
                CTRL_RUN: begin
                    r_rd_addr <= bus.rd_addr_i;
                    r_wreg    <= w_ex_wreg;
                    r_wdata   <= w_ex_wdata;
                end
                CTRL_FLUSH: begin
                    r_rd_addr <= '0;
                    r_wreg    <= 1'b0;
                    r_wdata   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_addr_o = r_rd_addr;
    assign bus.wreg_o    = r_wreg;
    assign bus.wdata_o   = r_wdata;

endmodule

// File: tb/tb_ex_ctrl_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_ctrl_stage
// Directed and randomized checks of ex_ctrl_stage against a behavioural
// reference model of the RV64I execute rules and the hazard policy.
// ---------------------------------------------------------------------------
module tb_ex_ctrl_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ex_ctrl_stage_if bus_if ();

    ex_ctrl_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        icache_valid;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] imm;
        logic [11:0] offset12;
        logic [63:0] pc;
        logic [4:0]  mb_rd;
        logic        mb_wreg;
        logic [63:0] mb_wdata;
    } stim_t;

    typedef struct packed {
        logic [63:0] wdata;
        logic        wreg;
        logic        taken;
        logic [63:0] target;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic stim_t blank();
        stim_t s;
        s = '0;
        s.icache_valid = 1'b1;
        return s;
    endfunction

    // Reference model: architectural meaning of each instruction.
    function automatic exp_t ref_model(input stim_t s);
        exp_t        e;
        logic [63:0] a, b, imm64;
        logic [31:0] w;
        logic        writes;
        logic        cond;
        e      = '0;
        writes = 1'b0;
        cond   = 1'b0;
        w      = '0;
        imm64  = {{32{s.imm[31]}}, s.imm};
        a = (s.mb_wreg && s.mb_rd != 5'd0 && s.mb_rd == s.rs1_addr) ? s.mb_wdata : s.rs1_data;
        b = (s.mb_wreg && s.mb_rd != 5'd0 && s.mb_rd == s.rs2_addr) ? s.mb_wdata : s.rs2_data;
        if (s.opcode == 7'h13 || s.opcode == 7'h33) begin
            writes = 1'b1;
            if (s.opcode == 7'h13) b = imm64;
            if (s.funct3 == 3'd0)      e.wdata = (s.opcode == 7'h33 && s.funct7[5]) ? a - b : a + b;
            else if (s.funct3 == 3'd1) e.wdata = a << b[5:0];
            else if (s.funct3 == 3'd2) e.wdata = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            else if (s.funct3 == 3'd3) e.wdata = (a < b) ? 64'd1 : 64'd0;
            else if (s.funct3 == 3'd4) e.wdata = a ^ b;
            else if (s.funct3 == 3'd5) begin
                if (s.funct7[5]) e.wdata = $signed(a) >>> b[5:0];
                else             e.wdata = a >> b[5:0];
            end
            else if (s.funct3 == 3'd6) e.wdata = a | b;
            else                       e.wdata = a & b;
        end else if (s.opcode == 7'h1B || s.opcode == 7'h3B) begin
            writes = 1'b1;
            if (s.opcode == 7'h1B) b = imm64;
            if (s.funct3 == 3'd0)      w = (s.opcode == 7'h3B && s.funct7[5]) ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
            else if (s.funct3 == 3'd1) w = a[31:0] << b[4:0];
            else if (s.funct3 == 3'd5) begin
                if (s.funct7[5]) w = $signed(a[31:0]) >>> b[4:0];
                else             w = a[31:0] >> b[4:0];
            end
            e.wdata = {{32{w[31]}}, w};
        end else if (s.opcode == 7'h37) begin
            writes = 1'b1; e.wdata = imm64;
        end else if (s.opcode == 7'h17) begin
            writes = 1'b1; e.wdata = s.pc + imm64;
        end else if (s.opcode == 7'h6F) begin
            writes = 1'b1; e.wdata = s.pc + 64'd4;
            e.taken = 1'b1; e.target = s.pc + imm64;
        end else if (s.opcode == 7'h67) begin
            writes = 1'b1; e.wdata = s.pc + 64'd4;
            e.taken = 1'b1; e.target = (a + imm64) & ~64'd1;
        end else if (s.opcode == 7'h63) begin
            case (s.funct3)
                3'd0: cond = (a == b);
                3'd1: cond = (a != b);
                3'd4: cond = ($signed(a) < $signed(b));
                3'd5: cond = ($signed(a) >= $signed(b));
                3'd6: cond = (a < b);
                3'd7: cond = (a >= b);
                default: cond = 1'b0;
            endcase
            e.taken  = cond;
            e.target = s.pc + {{51{s.offset12[11]}}, s.offset12, 1'b0};
        end
        e.wreg = s.wreg && (s.rd != 5'd0) && writes;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        bus_if.icache_data_valid_i = s.icache_valid;
        bus_if.rs1_addr_i          = s.rs1_addr;
        bus_if.rs2_addr_i          = s.rs2_addr;
        bus_if.opcode_i            = s.opcode;
        bus_if.funct3_i            = s.funct3;
        bus_if.funct7_i            = s.funct7;
        bus_if.rs1_data_i          = s.rs1_data;
        bus_if.rs2_data_i          = s.rs2_data;
        bus_if.rd_addr_i           = s.rd;
        bus_if.wreg_i              = s.wreg;
        bus_if.imm_i               = s.imm;
        bus_if.offset12_i          = s.offset12;
        bus_if.pc_i                = s.pc;
        bus_if.mem_back_rd_addr_i  = s.mb_rd;
        bus_if.mem_back_wreg_i     = s.mb_wreg;
        bus_if.mem_back_wdata_i    = s.mb_wdata;
    endtask

    // Called just after a rising edge: drive, check combinational outputs,
    // then check what EX/MEM captured on the next edge.
    task automatic do_step(input string tag, input stim_t s);
        exp_t       e;
        logic [1:0] c_pc, c_ifid, c_idex;
        e = ref_model(s);
        if (e.taken) begin
            c_pc = 2'b10; c_ifid = 2'b10; c_idex = 2'b10;
        end else if (!s.icache_valid) begin
            c_pc = 2'b01; c_ifid = 2'b10; c_idex = 2'b00;
        end else begin
            c_pc = 2'b00; c_ifid = 2'b00; c_idex = 2'b00;
        end
        apply(s);
        #1;
        chk({tag, ".ex_rd"},    64'(bus_if.ex_back_rd_addr_o), 64'(s.rd));
        chk({tag, ".ex_wreg"},  64'(bus_if.ex_back_wreg_o),    64'(e.wreg));
        chk({tag, ".ex_wdata"}, bus_if.ex_back_wdata_o,        e.wdata);
        chk({tag, ".ctl_pc"},   64'(bus_if.ctrl_signal_pc_o),     64'(c_pc));
        chk({tag, ".ctl_ifid"}, 64'(bus_if.ctrl_signal_if_id_o),  64'(c_ifid));
        chk({tag, ".ctl_idex"}, 64'(bus_if.ctrl_signal_id_ex_o),  64'(c_idex));
        chk({tag, ".ctl_mwb"},  64'(bus_if.ctrl_signal_mem_wb_o), 64'(2'b00));
        chk({tag, ".pc_new"},   bus_if.ctrl_to_pc_new_o, e.taken ? e.target : 64'd0);
        @(posedge clk);
        #1;
        chk({tag, ".rd_o"},    64'(bus_if.rd_addr_o), 64'(s.rd));
        chk({tag, ".wreg_o"},  64'(bus_if.wreg_o),    64'(e.wreg));
        chk({tag, ".wdata_o"}, bus_if.wdata_o,        e.wdata);
        $display("step %s op=%h f3=%0d wdata=%h wreg=%0d taken=%0d target=%h",
                 tag, s.opcode, s.funct3, e.wdata, e.wreg, e.taken, e.target);
    endtask

    task automatic chk_ex_mem_zero(input string tag);
        chk({tag, ".rd_o"},    64'(bus_if.rd_addr_o), 64'd0);
        chk({tag, ".wreg_o"},  64'(bus_if.wreg_o),    64'd0);
        chk({tag, ".wdata_o"}, bus_if.wdata_o,        64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [6:0] opc_tab [12];

    initial begin
        stim_t s;
        total = 0;
        bad   = 0;
        opc_tab = '{7'h13, 7'h33, 7'h1B, 7'h3B, 7'h37, 7'h17,
                    7'h6F, 7'h67, 7'h63, 7'h63, 7'h03, 7'h00};
        rst = 1'b1;
        apply(blank());
        #2 rst = 1'b0;
        #1 chk_ex_mem_zero("reset");
        @(posedge clk);
        #1 chk_ex_mem_zero("reset_hold");
        rst = 1'b1;

        // ADDI x5, x1(=10), -3
        s = blank();
        s.opcode = 7'h13; s.rs1_addr = 5'd1; s.rs1_data = 64'd10;
        s.imm = 32'hFFFF_FFFD; s.rd = 5'd5; s.wreg = 1'b1;
        do_step("addi", s);
        chk("addi.wdata_k", bus_if.wdata_o, 64'd7);
        chk("addi.rd_k",    64'(bus_if.rd_addr_o), 64'd5);
        chk("addi.wreg_k",  64'(bus_if.wreg_o), 64'd1);
        chk("addi.pc_k",    64'(bus_if.ctrl_signal_pc_o), 64'd0);

        // Reset mid-stream clears EX/MEM at once
        rst = 1'b0;
        #1 chk_ex_mem_zero("midrst");
        #1 rst = 1'b1;

        // SRAW
        s = blank();
        s.opcode = 7'h3B; s.funct3 = 3'd5; s.funct7 = 7'h20;
        s.rs1_addr = 5'd1; s.rs1_data = 64'h0000_0000_8000_0000;
        s.rs2_addr = 5'd2; s.rs2_data = 64'd4; s.rd = 5'd6; s.wreg = 1'b1;
        do_step("sraw", s);
        chk("sraw.wdata_k", bus_if.wdata_o, 64'hFFFF_FFFF_F800_0000);

        // Forwarding from MEM, then the same with rd=0 (no forwarding)
        s = blank();
        s.opcode = 7'h33; s.rs1_addr = 5'd3; s.rs1_data = 64'd1;
        s.rs2_addr = 5'd4; s.rs2_data = 64'd1; s.rd = 5'd7; s.wreg = 1'b1;
        s.mb_rd = 5'd3; s.mb_wreg = 1'b1; s.mb_wdata = 64'd100;
        do_step("fwd", s);
        chk("fwd.wdata_k", bus_if.wdata_o, 64'd101);
        s.mb_rd = 5'd0;
        do_step("fwd_x0", s);
        chk("fwd_x0.wdata_k", bus_if.wdata_o, 64'd2);

        // BNE taken / not taken
        s = blank();
        s.opcode = 7'h63; s.funct3 = 3'd1; s.rs1_addr = 5'd1; s.rs2_addr = 5'd2;
        s.rs1_data = 64'd1; s.rs2_data = 64'd2; s.pc = 64'h100; s.offset12 = 12'h008;
        do_step("bne_t", s);
        chk("bne_t.pc_new_k", bus_if.ctrl_to_pc_new_o, 64'h110);
        chk("bne_t.pc_k",     64'(bus_if.ctrl_signal_pc_o), 64'd2);
        chk("bne_t.idex_k",   64'(bus_if.ctrl_signal_id_ex_o), 64'd2);
        s.rs2_data = 64'd1;
        do_step("bne_nt", s);
        chk("bne_nt.pc_new_k", bus_if.ctrl_to_pc_new_o, 64'd0);
        chk("bne_nt.ifid_k",   64'(bus_if.ctrl_signal_if_id_o), 64'd0);

        // JALR with simultaneous icache miss: redirect wins
        s = blank();
        s.opcode = 7'h67; s.rs1_addr = 5'd1; s.rs1_data = 64'h2001; s.imm = 32'd2;
        s.pc = 64'h40; s.rd = 5'd1; s.wreg = 1'b1; s.icache_valid = 1'b0;
        do_step("jalr", s);
        chk("jalr.pc_new_k", bus_if.ctrl_to_pc_new_o, 64'h2002);
        chk("jalr.wdata_k",  bus_if.wdata_o, 64'h44);
        chk("jalr.pc_k",     64'(bus_if.ctrl_signal_pc_o), 64'd2);

        // icache miss alone
        s = blank();
        s.icache_valid = 1'b0;
        do_step("imiss", s);
        chk("imiss.pc_k",   64'(bus_if.ctrl_signal_pc_o), 64'd1);
        chk("imiss.ifid_k", 64'(bus_if.ctrl_signal_if_id_o), 64'd2);

        // Randomized instructions
        for (int n = 0; n < 300; n++) begin
            s = blank();
            s.opcode = opc_tab[$urandom_range(0, 11)];
            s.funct3 = 3'($urandom_range(0, 7));
            if (s.opcode == 7'h1B || s.opcode == 7'h3B) begin
                case ($urandom_range(0, 2))
                    0:       s.funct3 = 3'd0;
                    1:       s.funct3 = 3'd1;
                    default: s.funct3 = 3'd5;
                endcase
            end
            s.funct7       = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            s.rs1_addr     = 5'($urandom_range(0, 7));
            s.rs2_addr     = 5'($urandom_range(0, 7));
            s.rd           = 5'($urandom_range(0, 7));
            s.wreg         = ($urandom_range(0, 3) != 0);
            s.rs1_data     = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15))
                                                         : {$urandom, $urandom};
            s.rs2_data     = ($urandom_range(0, 3) == 0) ? s.rs1_data : {$urandom, $urandom};
            s.imm          = $urandom;
            s.offset12     = 12'($urandom);
            s.pc           = {$urandom, $urandom} & ~64'd3;
            s.mb_rd        = 5'($urandom_range(0, 7));
            s.mb_wreg      = ($urandom_range(0, 1) == 1);
            s.mb_wdata     = {$urandom, $urandom};
            s.icache_valid = ($urandom_range(0, 3) != 0);
            do_step($sformatf("rnd%0d", n), s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
